edge_frame_sequencer: RTL and testbench
=======================================

// Module: edge_frame_sequencer
// PURPOSE
//  Frame-level controller for the Sobel edge engine. Waits for the camera to finish a frame,
//  freezes camera writes into the picture BRAM, runs the Sobel engine over it, then swaps the
//  ping-pong edge BRAMs so display reads the new edge map. Also handles timeout/abort, one-deep
//  request queueing, and frame/overrun counting.
// PARAMETERS
//  SETTLE_CYCLES  4          cycles camera writes stay gated before sobel_start rises (min 1)
//  TIMEOUT_CYCLES 8_000_000  max cycles in RUN before abort (full 640x480 pass ~4.7M cycles)
//  CNT_W          24         width of the RUN watchdog counter
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous reset, active-low
//  enable         in   1   1 = accept new frames (switch); 0 = finish current, start none
//  frame_captured in   1   1-cycle pulse: camera completed a frame in picture BRAM
//  cam_we_in      in   1   camera write-enable into picture BRAM
//  cam_we_out     out  1   gated write-enable to BRAM = cam_we_in & (state==IDLE)
//  sobel_start    out  1   level to Sobel engine; low holds engine in setup/reset
//  sobel_done     in   1   Sobel engine done level (held until sobel_start falls)
//  edge_wr_sel    out  1   edge BRAM bank the Sobel engine writes
//  disp_rd_sel    out  1   edge BRAM bank the display reads (always ~edge_wr_sel)
//  frame_ready    out  1   1-cycle pulse: new edge map swapped to display
//  busy           out  1   1 when state != IDLE
//  timeout_err    out  1   sticky: a RUN timed out; cleared by err_clr
//  err_clr        in   1   1-cycle pulse, clears timeout_err
//  frame_count    out  8   completed frames, wraps 255->0
//  overrun_count  out  8   frame_captured pulses dropped, saturates at 255
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, sobel_start=0, edge_wr_sel=0, disp_rd_sel=1,
//   frame_ready=0, timeout_err=0, pending=0, counters=0. Low sobel_start resets the engine mid-pass.
//  States: IDLE, FREEZE, RUN, SWAP, ABORT; all outputs registered except cam_we_out, busy.
//  IDLE: frame_captured|pending with enable=1 -> FREEZE at next edge, clear pending, load settle cnt.
//   frame_captured with enable=0 is ignored (not counted).
//  FREEZE: cam_we_out=0; after SETTLE_CYCLES cycles -> RUN, sobel_start<=1, watchdog<=0.
//  RUN: sobel_start=1; watchdog +1/cycle. sobel_done ignored on first RUN cycle (stale guard).
//   sobel_done=1 -> SWAP. watchdog==TIMEOUT_CYCLES-1 without done -> ABORT. Both same cycle: done wins.
//  SWAP (1 cycle): sobel_start<=0, edge_wr_sel<=~edge_wr_sel, disp_rd_sel<=edge_wr_sel,
//   frame_ready=1 for this cycle only, frame_count+1. Next: FREEZE if pending&enable, else IDLE.
//  ABORT (1 cycle): sobel_start<=0, timeout_err<=1, no swap, no frame_ready, no count -> IDLE.
//  Queue: frame_captured while busy sets pending (1 deep); if pending already set, overrun_count+1
//   (saturating). Camera frames written while gated are lost by design.
//  err_clr and a new timeout in the same cycle: timeout_err stays 1.
//  Latency: frame_captured (cycle t, IDLE) -> cam_we_out low t+1 -> sobel_start high t+1+SETTLE_CYCLES.
//  enable falling mid-RUN does not abort; the pass completes and swaps.
// TESTING
//  1 Reset, enable=1, pulse frame_captured; model done after 100 RUN cycles -> sobel_start high at
//    t+5, low in SWAP; frame_ready one pulse; edge_wr_sel 0->1, disp_rd_sel 1->0; frame_count=1.
//  2 TIMEOUT_CYCLES=50, done never asserted -> ABORT after 50 RUN cycles; timeout_err=1, sel bits
//    unchanged, frame_count=0; err_clr pulse -> timeout_err=0.
//  3 Three frame_captured pulses during RUN -> pending=1, overrun_count=2; after SWAP goes straight
//    to FREEZE, second pass runs; frame_count=2.
//  4 enable=0 then frame_captured -> stays IDLE, cam_we_out tracks cam_we_in, busy=0; enable drop
//    mid-RUN -> pass still completes with frame_ready.
//  5 rst_n low mid-RUN (async, between edges) -> sobel_start=0, sel bits 0/1, counters 0 immediately.
//  6 done and watchdog expiry same cycle -> SWAP taken, timeout_err stays 0.

Source files
------------

// File: rtl/edge_frame_sequencer.sv
// edge_frame_sequencer: freezes camera writes, runs a Sobel pass, then swaps the ping-pong edge banks
module edge_frame_sequencer #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 8_000_000,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_captured,
  input  logic       cam_we_in,
  output logic       cam_we_out,
  output logic       sobel_start,
  input  logic       sobel_done,
  output logic       edge_wr_sel,
  output logic       disp_rd_sel,
  output logic       frame_ready,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic [7:0] frame_count,
  output logic [7:0] overrun_count
);
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, FREEZE, RUN, SWAP, ABORT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [7:0] frames_q, frames_d, overrun_q, overrun_d;
  logic pending_q, pending_d, start_q, start_d, wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic ready_q, ready_d, err_q, err_d;
  logic go, done_ok, to_swap, to_abort, requeue, drop;
  always_comb begin
    go        = enable && (frame_captured || pending_q);
    done_ok   = sobel_done && (wd_q != '0);
    to_swap   = (state_q == RUN) && done_ok;
    to_abort  = (state_q == RUN) && !done_ok && (wd_q == WD_LAST);
    requeue   = pending_q && enable;
    drop      = (state_q != IDLE) && frame_captured && pending_q && !((state_q == SWAP) && requeue);
    state_d   = state_q == IDLE   ? (go ? FREEZE : IDLE)
              : state_q == FREEZE ? (settle_q == '0 ? RUN : FREEZE)
              : state_q == RUN    ? (to_swap ? SWAP : to_abort ? ABORT : RUN)
              : state_q == SWAP   ? (requeue ? FREEZE : IDLE)
              : IDLE;
    settle_d  = state_q == FREEZE ? settle_q - SW'(1) : SETTLE_LAST;
    wd_d      = state_q == RUN ? wd_q + CNT_W'(1) : '0;
    start_d   = (state_q == FREEZE && settle_q == '0) ? 1'b1 : (to_swap || to_abort) ? 1'b0 : start_q;
    wr_sel_d  = to_swap ? ~wr_sel_q : wr_sel_q;
    rd_sel_d  = to_swap ? wr_sel_q : rd_sel_q;
    ready_d   = to_swap;
    frames_d  = to_swap ? frames_q + 8'd1 : frames_q;
    err_d     = to_abort || (err_q && !err_clr);
    pending_d = state_q == IDLE ? (go ? 1'b0 : pending_q)
              : (state_q == SWAP && requeue) ? frame_captured
              : pending_q || frame_captured;
    overrun_d = (drop && overrun_q != 8'hFF) ? overrun_q + 8'd1 : overrun_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      settle_q  <= SETTLE_LAST;
      wd_q      <= '0;
      start_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      frames_q  <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      wd_q      <= wd_d;
      start_q   <= start_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      frames_q  <= frames_d;
      overrun_q <= overrun_d;
    end
  end
  assign cam_we_out    = cam_we_in && (state_q == IDLE);
  assign busy          = state_q != IDLE;
  assign sobel_start   = start_q;
  assign edge_wr_sel   = wr_sel_q;
  assign disp_rd_sel   = rd_sel_q;
  assign frame_ready   = ready_q;
  assign timeout_err   = err_q;
  assign frame_count   = frames_q;
  assign overrun_count = overrun_q;
endmodule

// File: tb/tb_edge_frame_sequencer.sv
// tb_edge_frame_sequencer: directed checks of the frame sequencer with a short watchdog
module tb_edge_frame_sequencer;
  localparam int TO = 150;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, frame_captured = 1'b0, cam_we_in = 1'b1;
  logic sobel_done = 1'b0, err_clr = 1'b0;
  logic cam_we_out, sobel_start, edge_wr_sel, disp_rd_sel, frame_ready, busy, timeout_err;
  logic [7:0] frame_count, overrun_count;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic en, fc, we, clr, exp_we, exp_busy;
  } vec_t;
  vec_t vecs[6];
  edge_frame_sequencer #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TO), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_captured(frame_captured),
    .cam_we_in(cam_we_in), .cam_we_out(cam_we_out), .sobel_start(sobel_start),
    .sobel_done(sobel_done), .edge_wr_sel(edge_wr_sel), .disp_rd_sel(disp_rd_sel),
    .frame_ready(frame_ready), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic start_pass();
    frame_captured = 1'b1;
    tick();
    frame_captured = 1'b0;
    for (int i = 0; i < 20 && !sobel_start; i++) tick();
    chk("pass_start", sobel_start, 1);
  endtask
  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ticks(2);
    rst_n = 1'b1;
    tick();
    chk("rst_start", sobel_start, 0);
    chk("rst_wr_sel", edge_wr_sel, 0);
    chk("rst_rd_sel", disp_rd_sel, 1);
    chk("rst_ready", frame_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_overrun", overrun_count, 0);
    chk("rst_we", cam_we_out, 1);
    // exact latency of one pass with done at the 100th RUN cycle
    frame_captured = 1'b1;
    tick();
    frame_captured = 1'b0;
    chk("t1_we_gated", cam_we_out, 0);
    chk("t1_busy", busy, 1);
    chk("t1_start_t1", sobel_start, 0);
    ticks(3);
    chk("t1_start_t4", sobel_start, 0);
    tick();
    chk("t1_start_t5", sobel_start, 1);
    ticks(99);
    chk("t1_run_end_ready", frame_ready, 0);
    chk("t1_run_end_start", sobel_start, 1);
    sobel_done = 1'b1;
    tick();
    sobel_done = 1'b0;
    chk("t1_swap_start", sobel_start, 0);
    chk("t1_swap_ready", frame_ready, 1);
    chk("t1_swap_wr", edge_wr_sel, 1);
    chk("t1_swap_rd", disp_rd_sel, 0);
    chk("t1_swap_frames", frame_count, 1);
    tick();
    chk("t1_idle_ready", frame_ready, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_we", cam_we_out, 1);
    // done already high on the first RUN cycle must be ignored
    start_pass();
    sobel_done = 1'b1;
    tick();
    chk("stale_ready", frame_ready, 0);
    chk("stale_start", sobel_start, 1);
    tick();
    sobel_done = 1'b0;
    chk("stale_swap_ready", frame_ready, 1);
    chk("stale_frames", frame_count, 2);
    chk("stale_wr", edge_wr_sel, 0);
    tick();
    // watchdog abort
    start_pass();
    ticks(TO - 1);
    chk("t2_last_run_start", sobel_start, 1);
    chk("t2_last_run_err", timeout_err, 0);
    tick();
    chk("t2_abort_start", sobel_start, 0);
    chk("t2_abort_err", timeout_err, 1);
    chk("t2_abort_ready", frame_ready, 0);
    chk("t2_abort_busy", busy, 1);
    tick();
    chk("t2_idle_busy", busy, 0);
    chk("t2_wr", edge_wr_sel, 0);
    chk("t2_rd", disp_rd_sel, 1);
    chk("t2_frames", frame_count, 2);
    chk("t2_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t2_err_clr", timeout_err, 0);
    // queueing: three requests during RUN
    start_pass();
    for (int i = 0; i < 3; i++) begin
      frame_captured = 1'b1;
      tick();
      frame_captured = 1'b0;
      tick();
    end
    chk("t3_overrun", overrun_count, 2);
    sobel_done = 1'b1;
    tick();
    sobel_done = 1'b0;
    chk("t3_swap_frames", frame_count, 3);
    chk("t3_swap_ready", frame_ready, 1);
    tick();
    chk("t3_refreeze_busy", busy, 1);
    chk("t3_refreeze_we", cam_we_out, 0);
    chk("t3_refreeze_start", sobel_start, 0);
    ticks(4);
    chk("t3_rerun_start", sobel_start, 1);
    tick();
    sobel_done = 1'b1;
    tick();
    sobel_done = 1'b0;
    chk("t3_frames2", frame_count, 4);
    chk("t3_overrun_hold", overrun_count, 2);
    tick();
    chk("t3_idle_busy", busy, 0);
    // enable low: requests ignored, camera passes through
    for (int i = 0; i < 6; i++) begin
      enable = vecs[i].en;
      frame_captured = vecs[i].fc;
      cam_we_in = vecs[i].we;
      err_clr = vecs[i].clr;
      #1;
      chk($sformatf("t4_vec%0d_we", i), cam_we_out, vecs[i].exp_we);
      tick();
      chk($sformatf("t4_vec%0d_busy", i), busy, vecs[i].exp_busy);
    end
    frame_captured = 1'b0;
    err_clr = 1'b0;
    cam_we_in = 1'b1;
    chk("t4_frames", frame_count, 4);
    enable = 1'b1;
    start_pass();
    enable = 1'b0;
    ticks(3);
    sobel_done = 1'b1;
    tick();
    sobel_done = 1'b0;
    chk("t4_drop_en_ready", frame_ready, 1);
    chk("t4_drop_en_frames", frame_count, 5);
    tick();
    chk("t4_drop_en_idle", busy, 0);
    enable = 1'b1;
    // done and watchdog expiry together
    start_pass();
    ticks(TO - 1);
    sobel_done = 1'b1;
    tick();
    sobel_done = 1'b0;
    chk("t6_ready", frame_ready, 1);
    chk("t6_err", timeout_err, 0);
    chk("t6_frames", frame_count, 6);
    tick();
    chk("t6_err_after", timeout_err, 0);
    chk("t6_busy", busy, 0);
    // asynchronous reset between edges mid-RUN
    start_pass();
    ticks(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_start", sobel_start, 0);
    chk("t5_wr", edge_wr_sel, 0);
    chk("t5_rd", disp_rd_sel, 1);
    chk("t5_frames", frame_count, 0);
    chk("t5_overrun", overrun_count, 0);
    chk("t5_busy", busy, 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("t5_post_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
